// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning path and its consumers.
package key_pkg;

  // Per-channel debounce state, 2-bit encoded.
  typedef enum logic [1:0] {
    REL   = 2'b00,  // stable released
    PFILT = 2'b01,  // candidate press being filtered
    HELD  = 2'b10,  // stable pressed
    RFILT = 2'b11   // candidate release being filtered
  } key_state_t;

  // 20 ms of stability at the 50 MHz board clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Keys are active-low on the board. The LED decoder uses the same constants.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and stability counter.
// The debounced level and the press/release strobes are all registered.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             ks_reg;
  key_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  // Bring the asynchronous pin into the clock domain; idles at released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= KEY_RELEASED;
      ks_reg    <= KEY_RELEASED;
    end else begin
      sync1_reg <= key_in;
      ks_reg    <= sync1_reg;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= REL;
      cnt_reg     <= '0;
      out_reg     <= KEY_RELEASED;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      out_reg     <= out_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // Next state: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // synced samples at the new level; any sample back at the old level aborts.
  // The counter holds its value on acceptance, so it never wraps.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    out_next     = out_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      REL: begin
        if (ks_reg == KEY_PRESSED) begin
          state_next = PFILT;
          cnt_next   = CNT_ONE;
        end
      end
      PFILT: begin
        if (ks_reg == KEY_RELEASED) begin
          state_next = REL;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          out_next   = KEY_PRESSED;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        if (ks_reg == KEY_RELEASED) begin
          state_next = RFILT;
          cnt_next   = CNT_ONE;
        end
      end
      RFILT: begin
        if (ks_reg == KEY_PRESSED) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = REL;
          out_next     = KEY_RELEASED;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = REL;
        cnt_next   = '0;
        out_next   = KEY_RELEASED;
      end
    endcase
  end

  assign key_out     = out_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning: NUM_KEYS independent synchronise+debounce
// channels producing clean active-low levels and one-clock press/release
// strobes. Nothing is shared or prioritised between channels.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // The filter needs at least a start sample and an accept sample.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  // One channel per key.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[gi]),
      .key_out    (key_out[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a short debounce window.
// Reference model: per key, the debounced level flips once the value seen on
// key_in two clock edges earlier has differed from it for D consecutive edges.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int D  = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_out, key_press, key_release;

  int n_checks = 0;
  int n_fail   = 0;

  key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_out    (key_out),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Reference model: delayed view of the pins plus a per-key run length of
  // samples that disagree with the current debounced level.
  logic [NK-1:0] seen_1, seen_2;
  logic [NK-1:0] exp_out, exp_press, exp_release;
  int            run_len [NK];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_1      <= '1;
      seen_2      <= '1;
      exp_out     <= '1;
      exp_press   <= '0;
      exp_release <= '0;
      for (int i = 0; i < NK; i++) run_len[i] <= 0;
    end else begin
      seen_1 <= key_in;
      seen_2 <= seen_1;
      for (int i = 0; i < NK; i++) begin
        exp_press[i]   <= 1'b0;
        exp_release[i] <= 1'b0;
        if (seen_2[i] == exp_out[i]) begin
          run_len[i] <= 0;
        end else if (run_len[i] + 1 == D) begin
          run_len[i]     <= 0;
          exp_out[i]     <= seen_2[i];
          exp_press[i]   <= ~seen_2[i];
          exp_release[i] <= seen_2[i];
        end else begin
          run_len[i] <= run_len[i] + 1;
        end
      end
    end
  end

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_out !== 4'b1111 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state out=%b press=%b rel=%b required out=1111 press=0000 rel=0000",
               key_out, key_press, key_release);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== 4'b1111 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d out=%b press=%b rel=%b required 1111/0000/0000",
                 c, key_out, key_press, key_release);
      end
    end
    $display("test_reset: idle 100 clks after reset");
  endtask

  task automatic test_clean_press;
    int press_at = -1;
    int n_press  = 0;
    int n_rel    = 0;
    key_in[0] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release) begin
        n_fail++;
        $display("FAIL clean_press_model cyc=%0d out=%b/%b press=%b/%b rel=%b/%b (got/required)",
                 c, key_out, exp_out, key_press, exp_press, key_release, exp_release);
      end
      if (key_press[0]) begin
        n_press++;
        press_at = c;
      end
    end
    n_checks++;
    if (press_at != D + 2 || n_press != 1) begin
      n_fail++;
      $display("FAIL clean_press_latency at=%0d count=%0d required at=%0d count=1",
               press_at, n_press, D + 2);
    end
    n_checks++;
    if (key_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL clean_press_level out=%b required 1110", key_out);
    end
    key_in[0] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release) begin
        n_fail++;
        $display("FAIL clean_release_model cyc=%0d out=%b/%b press=%b/%b rel=%b/%b (got/required)",
                 c, key_out, exp_out, key_press, exp_press, key_release, exp_release);
      end
      if (key_release[0]) n_rel++;
    end
    n_checks++;
    if (n_rel != 1 || key_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL clean_release count=%0d out=%b required count=1 out=1111", n_rel, key_out);
    end
    $display("test_clean_press: press strobe at clk %0d", press_at);
  endtask

  task automatic test_bounce;
    int n_press = 0;
    int lo, hi;
    for (int b = 0; b < 8; b++) begin
      lo = (b < 4) ? 5 : $urandom_range(D - 1, 1);
      hi = (b < 4) ? 3 : $urandom_range(4, 1);
      for (int c = 0; c < lo + hi; c++) begin
        key_in[1] = (c < lo) ? 1'b0 : 1'b1;
        @(negedge clk);
        n_checks++;
        if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release ||
            key_out[1] !== 1'b1 || key_press !== 4'b0000) begin
          n_fail++;
          $display("FAIL bounce_reject b=%0d out=%b/%b press=%b/%b rel=%b/%b (got/required)",
                   b, key_out, exp_out, key_press, exp_press, key_release, exp_release);
        end
      end
    end
    key_in[1] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release) begin
        n_fail++;
        $display("FAIL bounce_hold_model cyc=%0d out=%b/%b press=%b/%b (got/required)",
                 c, key_out, exp_out, key_press, exp_press);
      end
      if (key_press[1]) n_press++;
    end
    n_checks++;
    if (n_press != 1 || key_out !== 4'b1101) begin
      n_fail++;
      $display("FAIL bounce_accept presses=%0d out=%b required presses=1 out=1101", n_press, key_out);
    end
    key_in[1] = 1'b1;
    repeat (14) @(negedge clk);
    $display("test_bounce: bursts rejected, steady press accepted");
  endtask

  task automatic test_boundary;
    int n_press = 0;
    int n_rel   = 0;
    for (int c = 0; c < 19; c++) begin
      key_in[2] = (c < D - 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_out[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL boundary_short cyc=%0d out=%b/%b press=%b/%b (got/required)",
                 c, key_out, exp_out, key_press, exp_press);
      end
    end
    for (int c = 0; c < 22; c++) begin
      key_in[2] = (c < D) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release) begin
        n_fail++;
        $display("FAIL boundary_exact cyc=%0d out=%b/%b press=%b/%b rel=%b/%b (got/required)",
                 c, key_out, exp_out, key_press, exp_press, key_release, exp_release);
      end
      if (key_press[2]) n_press++;
      if (key_release[2]) n_rel++;
    end
    n_checks++;
    if (n_press != 1 || n_rel != 1) begin
      n_fail++;
      $display("FAIL boundary_accept presses=%0d releases=%0d required 1/1", n_press, n_rel);
    end
    $display("test_boundary: %0d-clk pulse rejected, %0d-clk pulse accepted", D - 1, D);
  endtask

  task automatic test_simultaneous;
    int n_all = 0;
    int n_part = 0;
    key_in = 4'b0000;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (key_press == 4'b1111) n_all++;
      else if (key_press != 4'b0000) n_part++;
    end
    n_checks++;
    if (n_all != 1 || n_part != 0 || key_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_press full=%0d partial=%0d out=%b required 1/0/0000", n_all, n_part, key_out);
    end
    n_all = 0;
    n_part = 0;
    key_in = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (key_release == 4'b1111) n_all++;
      else if (key_release != 4'b0000) n_part++;
      n_checks++;
      if ((key_press & key_release) !== 4'b0000) begin
        n_fail++;
        $display("FAIL simul_exclusive press=%b rel=%b required no overlap", key_press, key_release);
      end
    end
    n_checks++;
    if (n_all != 1 || n_part != 0 || key_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL simul_release full=%0d partial=%0d out=%b required 1/0/1111", n_all, n_part, key_out);
    end
    $display("test_simultaneous: all keys strobed together");
  endtask

  task automatic test_reset_mid;
    int press_at = -1;
    key_in[3] = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_out !== 4'b1111 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_state out=%b press=%b rel=%b required 1111/0000/0000",
               key_out, key_press, key_release);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (key_press !== 4'b0000 || key_out !== 4'b1111) begin
        n_fail++;
        $display("FAIL reset_mid_hold out=%b press=%b required 1111/0000", key_out, key_press);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release) begin
        n_fail++;
        $display("FAIL reset_mid_model cyc=%0d out=%b/%b press=%b/%b (got/required)",
                 c, key_out, exp_out, key_press, exp_press);
      end
      if (key_press[3] && press_at < 0) press_at = c;
    end
    n_checks++;
    if (press_at != D + 2) begin
      n_fail++;
      $display("FAIL reset_mid_latency at=%0d required %0d", press_at, D + 2);
    end
    key_in[3] = 1'b1;
    repeat (14) @(negedge clk);
    $display("test_reset_mid: press after reset at clk %0d", press_at);
  endtask

  task automatic test_random;
    int n_press = 0;
    int n_rel   = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(5, 0) == 0) key_in[i] = ~key_in[i];
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out || key_press !== exp_press || key_release !== exp_release ||
          (key_press & key_release) !== 4'b0000) begin
        n_fail++;
        $display("FAIL random cyc=%0d in=%b out=%b/%b press=%b/%b rel=%b/%b (got/required)",
                 c, key_in, key_out, exp_out, key_press, exp_press, key_release, exp_release);
      end
      n_press += $countones(key_press);
      n_rel   += $countones(key_release);
    end
    key_in = '1;
    repeat (14) @(negedge clk);
    $display("test_random: 600 clks, %0d presses, %0d releases", n_press, n_rel);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_boundary();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
